// File: rtl/mac_pe_array_cell.sv
// Systolic MAC cell: forwards A/B operands, accumulates k products,
// drains a scaled, saturated result down a column chain. Option: MAC_SAT_ACC_EN.
module mac_pe_array_cell #(
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  parameter int KW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [KW-1:0] k_len_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          in_valid_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic          valid_o,
  input  logic          drain_i,
  input  logic [OW-1:0] res_i,
  input  logic          res_valid_i,
  output logic [OW-1:0] res_o,
  output logic          res_valid_o,
  output logic          done_o,
  output logic          busy_o
`ifdef MAC_SAT_ACC_EN
  ,output logic         ovf_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FULL,
    DRAIN
  } state_t;

  localparam logic signed [AW-1:0] OMAX =
    {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN =
    {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_x;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [AW-1:0]   acc_add;
  logic signed [AW-1:0]   shf;
  logic [KW-1:0]          cnt_q, cnt_d;
  logic [OW-1:0]          res_sat;
  logic [OW-1:0]          res_d;
  logic                   res_valid_d;

  assign prod   = (2*DW)'($signed(a_i)) * (2*DW)'($signed(b_i));
  assign prod_x = AW'(prod);

`ifdef MAC_SAT_ACC_EN
  localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW:0] sum_w;
  logic               ovf_hit;
  logic               ovf_q, ovf_d;

  // one extra bit exposes signed overflow of the add
  assign sum_w   = (AW+1)'(acc_q) + (AW+1)'(prod_x);
  assign ovf_hit = sum_w[AW] ^ sum_w[AW-1];
  assign acc_add = !ovf_hit  ? sum_w[AW-1:0] :
                   sum_w[AW] ? AMIN : AMAX;
  assign ovf_o   = ovf_q;
`else
  assign acc_add = acc_q + prod_x;
`endif

  assign shf = acc_q >>> SHIFT;

  always_comb begin
    res_sat = shf[OW-1:0];
    if (shf > OMAX) begin
      res_sat = OMAX[OW-1:0];
    end else if (shf < OMIN) begin
      res_sat = OMIN[OW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_d       = res_o;
    res_valid_d = res_valid_o;
`ifdef MAC_SAT_ACC_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        if (start_i) begin
          if (k_len_i != '0) begin
            state_d = ACC;
            cnt_d   = k_len_i;
`ifdef MAC_SAT_ACC_EN
            ovf_d   = 1'b0;
`endif
          end else begin
            state_d = FULL;
          end
        end
      end
      ACC: begin
        if (in_valid_i) begin
          acc_d = acc_add;
          cnt_d = cnt_q - KW'(1);
`ifdef MAC_SAT_ACC_EN
          ovf_d = ovf_q | ovf_hit;
`endif
          if (cnt_q == KW'(1)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (drain_i) begin
          res_d       = res_sat;
          res_valid_d = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_i) begin
          res_d       = res_i;
          res_valid_d = res_valid_i;
        end else begin
          state_d     = IDLE;
          acc_d       = '0;
          res_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_o       <= '0;
      res_valid_o <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      valid_o     <= 1'b0;
`ifdef MAC_SAT_ACC_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_o       <= res_d;
      res_valid_o <= res_valid_d;
      a_o         <= a_i;
      b_o         <= b_i;
      valid_o     <= in_valid_i;
`ifdef MAC_SAT_ACC_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign done_o = (state_q == FULL);
  assign busy_o = (state_q == ACC) || (state_q == DRAIN);

endmodule

// File: tb/tb_mac_pe_array_cell.sv
// Bench: 3-cell drain column (SHIFT=0) plus a SHIFT=4 cell mirroring
// the bottom cell's inputs; results scored against an arithmetic model.
module tb_mac_pe_array_cell;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic reset;
  logic drain;
  always #5 clk = ~clk;

  logic          start_v [3];
  logic [KW-1:0] k_v     [3];
  logic [DW-1:0] a_v     [3];
  logic [DW-1:0] b_v     [3];
  logic          iv_v    [3];

  logic [DW-1:0] ao_v   [4];
  logic [DW-1:0] bo_v   [4];
  logic          vo_v   [4];
  logic [OW-1:0] res_v  [4];
  logic          rv_v   [4];
  logic          done_v [4];
  logic          busy_v [4];
`ifdef MAC_SAT_ACC_EN
  logic          ovf_v  [4];
`endif

  logic [OW-1:0] rin  [3];
  logic          rvin [3];
  assign rin[0]  = '0;
  assign rvin[0] = 1'b0;
  assign rin[1]  = res_v[0];
  assign rvin[1] = rv_v[0];
  assign rin[2]  = res_v[1];
  assign rvin[2] = rv_v[1];

  for (genvar c = 0; c < 3; c++) begin : g_col
    mac_pe_array_cell #(
      .DW(DW), .AW(AW), .OW(OW), .SHIFT(0), .KW(KW)
    ) u_cell (
      .clk(clk),
      .reset(reset),
      .start_i(start_v[c]),
      .k_len_i(k_v[c]),
      .a_i(a_v[c]),
      .b_i(b_v[c]),
      .in_valid_i(iv_v[c]),
      .a_o(ao_v[c]),
      .b_o(bo_v[c]),
      .valid_o(vo_v[c]),
      .drain_i(drain),
      .res_i(rin[c]),
      .res_valid_i(rvin[c]),
      .res_o(res_v[c]),
      .res_valid_o(rv_v[c]),
      .done_o(done_v[c]),
      .busy_o(busy_v[c])
`ifdef MAC_SAT_ACC_EN
      ,.ovf_o(ovf_v[c])
`endif
    );
  end

  mac_pe_array_cell #(
    .DW(DW), .AW(AW), .OW(OW), .SHIFT(4), .KW(KW)
  ) u_s4 (
    .clk(clk),
    .reset(reset),
    .start_i(start_v[2]),
    .k_len_i(k_v[2]),
    .a_i(a_v[2]),
    .b_i(b_v[2]),
    .in_valid_i(iv_v[2]),
    .a_o(ao_v[3]),
    .b_o(bo_v[3]),
    .valid_o(vo_v[3]),
    .drain_i(drain),
    .res_i('0),
    .res_valid_i(1'b0),
    .res_o(res_v[3]),
    .res_valid_o(rv_v[3]),
    .done_o(done_v[3]),
    .busy_o(busy_v[3])
`ifdef MAC_SAT_ACC_EN
    ,.ovf_o(ovf_v[3])
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_on = 1'b0;
  logic [OW-1:0] q0[$];
  logic [OW-1:0] q4[$];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // model: sum of products, wrapped or clamped per product, then scaled
  function automatic longint m_acc(input int n, input int av[8],
                                   input int bv[8]);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = s + longint'(av[i]) * longint'(bv[i]);
`ifdef MAC_SAT_ACC_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
      s = longint'(int'(s[31:0]));
`endif
    end
    return s;
  endfunction

  function automatic logic [OW-1:0] m_res(input longint acc, input int sh);
    longint r;
    r = acc >>> sh;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[OW-1:0];
  endfunction

  logic [DW-1:0] pa [4];
  logic [DW-1:0] pb [4];
  logic          pv [4];
  logic          prst;

  always @(posedge clk) begin
    prst <= reset;
    for (int c = 0; c < 4; c++) begin
      pa[c] <= a_v[c < 3 ? c : 2];
      pb[c] <= b_v[c < 3 ? c : 2];
      pv[c] <= iv_v[c < 3 ? c : 2];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < 4; c++) begin
        check("fwd_a", ao_v[c], prst ? '0 : pa[c]);
        check("fwd_b", bo_v[c], prst ? '0 : pb[c]);
        check("fwd_v", vo_v[c], prst ? 1'b0 : pv[c]);
      end
      if (rv_v[2]) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL res_bot got=valid %0h exp=none", res_v[2]);
        end else begin
          check("res_bot", res_v[2], q0.pop_front());
        end
      end
      if (rv_v[3]) begin
        if (q4.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL res_s4 got=valid %0h exp=none", res_v[3]);
        end else begin
          check("res_s4", res_v[3], q4.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c, input int k);
    start_v[c] = 1'b1;
    k_v[c]     = KW'(k);
    tick();
    start_v[c] = 1'b0;
  endtask

  task automatic feed(input int c, input int av, input int bv);
    a_v[c]  = DW'(av);
    b_v[c]  = DW'(bv);
    iv_v[c] = 1'b1;
    tick();
    iv_v[c] = 1'b0;
  endtask

  task automatic drain_n(input int n);
    drain = 1'b1;
    repeat (n) tick();
    drain = 1'b0;
    tick();
  endtask

  task automatic idle_chk(input string nm);
    check({nm, "_done"}, done_v[2], 1'b0);
    check({nm, "_busy"}, busy_v[2], 1'b0);
    check({nm, "_rv"}, rv_v[2], 1'b0);
  endtask

  longint acc6;

  initial begin
    reset = 1'b1;
    drain = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start_v[c] = 1'b0;
      k_v[c]     = '0;
      a_v[c]     = '0;
      b_v[c]     = '0;
      iv_v[c]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    reset  = 1'b0;
    idle_chk("rst");
    check("rst_res", res_v[2], 16'h0000);
    check("rst_vo", vo_v[2], 1'b0);
`ifdef MAC_SAT_ACC_EN
    check("rst_ovf", ovf_v[2], 1'b0);
`endif

    // 1: three products, FULL holds through a stray pair
    go(2, 3);
    check("t1_busy", busy_v[2], 1'b1);
    feed(2, 2, 3);
    feed(2, -4, 5);
    check("t1_done_early", done_v[2], 1'b0);
    feed(2, 7, 1);
    check("t1_done", done_v[2], 1'b1);
    check("t1_busy_full", busy_v[2], 1'b0);
    q0.push_back(16'hFFF9);
    q4.push_back(16'hFFFF);
    feed(2, 100, 100);
    check("t1_hold", done_v[2], 1'b1);
    drain_n(1);
    idle_chk("t1_end");
    check("t1_res_held", res_v[2], 16'hFFF9);

    // 2: positive clamp, and SHIFT=4 scaling
    go(2, 1);
    feed(2, 300, 300);
    q0.push_back(16'h7FFF);
    q4.push_back(16'h15F9);
    drain_n(1);

    // 3: column drain order, bottom first
    for (int c = 0; c < 3; c++) begin
      start_v[c] = 1'b1;
      k_v[c]     = KW'(1);
    end
    tick();
    for (int c = 0; c < 3; c++) start_v[c] = 1'b0;
    a_v[0] = 16'd2;  b_v[0] = 16'd5;
    a_v[1] = 16'd4;  b_v[1] = 16'd5;
    a_v[2] = 16'd5;  b_v[2] = 16'd6;
    for (int c = 0; c < 3; c++) iv_v[c] = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) iv_v[c] = 1'b0;
    check("t3_done0", done_v[0], 1'b1);
    check("t3_done1", done_v[1], 1'b1);
    q0.push_back(16'd30);
    q0.push_back(16'd20);
    q0.push_back(16'd10);
    q4.push_back(m_res(30, 4));
    drain_n(3);
    check("t3_busy0", busy_v[0], 1'b0);
    idle_chk("t3_end");

    // 4: zero-length accumulation
    go(2, 0);
    check("t4_done", done_v[2], 1'b1);
    check("t4_busy", busy_v[2], 1'b0);
    q0.push_back(16'h0000);
    q4.push_back(16'h0000);
    drain_n(1);

    // 5: reset mid-accumulation
    go(2, 4);
    feed(2, 5, 5);
    feed(2, 6, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_chk("t5_rst");
    check("t5_res", res_v[2], 16'h0000);
    go(2, 1);
    feed(2, 1, 1);
    q0.push_back(16'h0001);
    q4.push_back(16'h0000);
    drain_n(1);

    // 6: accumulator overflow
    go(2, 3);
    feed(2, -32768, -32768);
`ifdef MAC_SAT_ACC_EN
    check("t6_ovf_early", ovf_v[2], 1'b0);
`endif
    feed(2, -32768, -32768);
    feed(2, -32768, -32768);
    check("t6_done", done_v[2], 1'b1);
    acc6 = m_acc(3, '{-32768, -32768, -32768, 0, 0, 0, 0, 0},
                    '{-32768, -32768, -32768, 0, 0, 0, 0, 0});
`ifdef MAC_SAT_ACC_EN
    check("t6_ovf", ovf_v[2], 1'b1);
    q0.push_back(16'h7FFF);
`else
    q0.push_back(16'h8000);
`endif
    q4.push_back(m_res(acc6, 4));
    drain_n(1);
`ifdef MAC_SAT_ACC_EN
    check("t6_ovf_sticky", ovf_v[2], 1'b1);
`endif

    // 7: gaps hold state; start and drain ignored while accumulating
    go(2, 2);
`ifdef MAC_SAT_ACC_EN
    check("t7_ovf_clr", ovf_v[2], 1'b0);
`endif
    feed(2, 3, 4);
    start_v[2] = 1'b1;
    k_v[2]     = KW'(5);
    drain      = 1'b1;
    tick();
    start_v[2] = 1'b0;
    drain      = 1'b0;
    check("t7_done_gap", done_v[2], 1'b0);
    check("t7_busy_gap", busy_v[2], 1'b1);
    check("t7_rv_gap", rv_v[2], 1'b0);
    feed(2, -6, 7);
    check("t7_done", done_v[2], 1'b1);
    acc6 = m_acc(2, '{3, -6, 0, 0, 0, 0, 0, 0},
                    '{4, 7, 0, 0, 0, 0, 0, 0});
    q0.push_back(m_res(acc6, 0));
    q4.push_back(m_res(acc6, 4));
    drain_n(1);

    tick();
    check("drained_bot", q0.size(), 0);
    check("drained_s4", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
